dsp_avg: RTL and testbench
==========================

# dsp_avg

Block-averaging stage directly downstream of the `dsp` magnitude/phase demodulator. Consumes the latched `mag_*` / `phase_*` set on each `out_strobe`, averages 2^`avg_log2` consecutive sets per channel, and presents one averaged set with a valid/ack handshake to the CSR readout. Phase averaging is wrap-safe: each lane accumulates deviations from the first sample of the block.

## Interface
- `W_CORDIC`, 31: magnitude width; phase width is `W_CORDIC+1`, signed, full scale = ±π
- `MAX_LOG2`, 15: largest supported `avg_log2`; accumulator width is `W+1+MAX_LOG2`
- `clk` in 1: sole clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: averaging enabled; low aborts the block in progress
- `avg_log2` in 4: block length exponent, 0..`MAX_LOG2`; values above clamp to `MAX_LOG2`
- `in_strobe` in 1: one-cycle pulse, input set valid (driven by `dsp.out_strobe`)
- `mag_ref/a/b/c` in `W_CORDIC` each: unsigned magnitudes
- `phase_ref/a/b/c` in `W_CORDIC+1` each: signed phases
- `avg_mag_ref/a/b/c` out `W_CORDIC` each: averaged magnitudes
- `avg_phase_ref/a/b/c` out `W_CORDIC+1` each: averaged phases
- `out_valid` out 1: averaged set available; held until acknowledged
- `out_ack` in 1: consumer acknowledge, one cycle, only meaningful while `out_valid`
- `overrun` out 1: sticky, a completed block overwrote an unacknowledged one

## Operation
- States: IDLE, ACC, DUMP.
- IDLE: on `in_strobe` with `enable` high → latch `avg_log2` (clamped) as `n_log2`, load each mag accumulator with the mag input, latch each phase input as `first_x`, clear phase accumulators, sample counter = 1. If `n_log2 == 0` → DUMP, else → ACC.
- ACC: each `in_strobe` → mag acc += mag; phase acc += sign-extend((phase − `first_x`) mod 2^(W+1)); counter += 1. When counter reaches 2^`n_log2` on a strobe → DUMP.
- DUMP (one cycle): avg_mag = mag acc >> `n_log2` (truncate); avg_phase = (`first_x` + (phase acc >>> `n_log2`)) mod 2^(W+1); `out_valid` ← 1; → IDLE. Inputs with `in_strobe` during DUMP are dropped.
- `enable` low in any state → IDLE next cycle, partial sums discarded; output registers, `out_valid`, `overrun` untouched.
- `avg_log2` changes take effect only at the next block start.
- Handshake: `out_ack` while `out_valid` → `out_valid` 0 and `overrun` 0 next cycle. DUMP while `out_valid` already 1 and no `out_ack` → outputs overwritten, `overrun` ← 1. DUMP and `out_ack` in the same cycle → new set loaded, `out_valid` stays 1, `overrun` cleared. `out_ack` while `out_valid` 0 → ignored.
- Mag sums cannot overflow given the accumulator width. Phase deviation sums are modular by design.

## Timing
- Reset values: state IDLE, all accumulators 0, all `avg_*` 0, `out_valid` 0, `overrun` 0, counter 0.
- The last strobe of a block is at cycle T. DUMP is at T+1. `avg_*` and `out_valid` are visible at T+2.
- Minimum strobe spacing is 2 cycles. `dsp` guarantees spacing ≥ 8.

## Configuration
- `DSP_AVG_OVF_CNT_EN` defined: adds output `overrun_cnt` [15:0], incremented on every overwrite, saturating at 0xFFFF. It is cleared only by `reset_n`.
- Not defined: the port is absent. Only the sticky `overrun` flag exists.

## Structure
- Package `dsp_pkg` holds:
  - `W_CORDIC` default and `MAX_LOG2`
  - the state enum (IDLE/ACC/DUMP)
  - the derived accumulator-width constant
- Sub-module `dsp_avg_lane`: one channel's mag accumulator, phase deviation accumulator, `first_x` register and DUMP arithmetic. It is instantiated 4× under a shared FSM and counter in `dsp_avg`.

## Test plan
- Constant input, `avg_log2`=2: mag_a=1000 and phase_a=0x1000_0000, 4 strobes → `avg_mag_a`=1000, `avg_phase_a`=0x1000_0000, `out_valid` at T+2.
- Wrap case, `avg_log2`=1: phase_b=0x7FFF_FFF0 then 0x8000_0010 → `avg_phase_b`=0x8000_0000 (not ≈0).
- Truncation, `avg_log2`=1: mags 3 and 4 → 3. Then `avg_log2`=0: every strobe produces an output with mag unchanged.
- Handshake: complete two blocks without ack → `overrun`=1 and outputs hold the second block. Ack on the same cycle as a third DUMP → `out_valid`=1, `overrun`=0.
- `enable` dropped after 2 of 4 strobes, re-raised, 4 more strobes → result reflects only the last 4. Changing `avg_log2` mid-block has no effect until the next block.
- Assert `reset_n` low mid-ACC → all outputs 0 asynchronously. With `DSP_AVG_OVF_CNT_EN`, 3 overwrites → `overrun_cnt`=3.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: widths, FSM state type and log2 clamp shared by the dsp_avg block-averager.
package dsp_pkg;
  localparam int W_CORDIC = 31;
  localparam int MAX_LOG2 = 15;
  localparam int W_PHASE  = W_CORDIC + 1;
  localparam int ACC_W    = W_CORDIC + 1 + MAX_LOG2;
  localparam int CNT_W    = MAX_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;
  function automatic logic [3:0] clamp_log2(input logic [3:0] v);
    return (int'(v) > MAX_LOG2) ? 4'(MAX_LOG2) : v;
  endfunction
endpackage

// File: rtl/dsp_avg_if.sv
// dsp_avg_if: demodulator input set and averaged-output handshake bus of dsp_avg.
interface dsp_avg_if;
  import dsp_pkg::*;
  logic                in_strobe, out_ack, out_valid, overrun;
  logic [W_CORDIC-1:0] mag_ref, mag_a, mag_b, mag_c;
  logic [W_PHASE-1:0]  phase_ref, phase_a, phase_b, phase_c;
  logic [W_CORDIC-1:0] avg_mag_ref, avg_mag_a, avg_mag_b, avg_mag_c;
  logic [W_PHASE-1:0]  avg_phase_ref, avg_phase_a, avg_phase_b, avg_phase_c;
  modport master (
    output in_strobe, out_ack, mag_ref, mag_a, mag_b, mag_c,
           phase_ref, phase_a, phase_b, phase_c,
    input  out_valid, overrun, avg_mag_ref, avg_mag_a, avg_mag_b, avg_mag_c,
           avg_phase_ref, avg_phase_a, avg_phase_b, avg_phase_c
  );
  modport slave (
    input  in_strobe, out_ack, mag_ref, mag_a, mag_b, mag_c,
           phase_ref, phase_a, phase_b, phase_c,
    output out_valid, overrun, avg_mag_ref, avg_mag_a, avg_mag_b, avg_mag_c,
           avg_phase_ref, avg_phase_a, avg_phase_b, avg_phase_c
  );
endinterface

// File: rtl/dsp_avg_lane.sv
// dsp_avg_lane: one channel's magnitude sum, phase-deviation sum, block reference phase and averaged output.
module dsp_avg_lane
  import dsp_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                acc_i,
  input  logic                dump_i,
  input  logic [3:0]          n_log2_i,
  input  logic [W_CORDIC-1:0] mag_i,
  input  logic [W_PHASE-1:0]  phase_i,
  output logic [W_CORDIC-1:0] avg_mag_o,
  output logic [W_PHASE-1:0]  avg_phase_o
);
  logic        [ACC_W-1:0]    mag_acc_q, mag_acc_d;
  logic signed [ACC_W-1:0]    ph_acc_q, ph_acc_d;
  logic        [W_PHASE-1:0]  first_q, first_d, avg_phase_q, avg_phase_d, dev;
  logic        [W_CORDIC-1:0] avg_mag_q, avg_mag_d;
  // phase deviations wrap modulo full scale, so a block straddling +-pi averages correctly
  always_comb begin
    dev         = phase_i - first_q;
    mag_acc_d   = start_i ? ACC_W'(mag_i) : acc_i ? mag_acc_q + ACC_W'(mag_i) : mag_acc_q;
    ph_acc_d    = start_i ? '0 : acc_i ? ph_acc_q + $signed({{(ACC_W-W_PHASE){dev[W_PHASE-1]}}, dev}) : ph_acc_q;
    first_d     = start_i ? phase_i : first_q;
    avg_mag_d   = dump_i ? W_CORDIC'(mag_acc_q >> n_log2_i) : avg_mag_q;
    avg_phase_d = dump_i ? first_q + W_PHASE'(ph_acc_q >>> n_log2_i) : avg_phase_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mag_acc_q   <= '0;
      ph_acc_q    <= '0;
      first_q     <= '0;
      avg_mag_q   <= '0;
      avg_phase_q <= '0;
    end else begin
      mag_acc_q   <= mag_acc_d;
      ph_acc_q    <= ph_acc_d;
      first_q     <= first_d;
      avg_mag_q   <= avg_mag_d;
      avg_phase_q <= avg_phase_d;
    end
  assign avg_mag_o   = avg_mag_q;
  assign avg_phase_o = avg_phase_q;
endmodule

// File: rtl/dsp_avg.sv
// dsp_avg: averages 2^avg_log2 demodulator sets on four lanes behind a valid/ack handshake.
// Defining DSP_AVG_OVF_CNT_EN adds a saturating overrun_cnt output.
module dsp_avg
  import dsp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  avg_log2,
`ifdef DSP_AVG_OVF_CNT_EN
  output logic [15:0] overrun_cnt,
`endif
  dsp_avg_if.slave    bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       n_log2_q, n_log2_d;
  logic             out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic             start, acc, dump, ack, ovw;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_log2_d = n_log2_q;
    start    = 1'b0;
    acc      = 1'b0;
    case (state_q)
      IDLE: if (bus.in_strobe) begin
        start    = 1'b1;
        n_log2_d = clamp_log2(avg_log2);
        cnt_d    = CNT_W'(1);
        state_d  = (n_log2_d == 4'd0) ? DUMP : ACC;
      end
      ACC: if (bus.in_strobe) begin
        acc   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == (CNT_W'(1) << n_log2_q)) state_d = DUMP;
      end
      default: state_d = IDLE;
    endcase
    // a disabled block is abandoned; published results are left alone
    if (!enable) begin
      state_d = IDLE;
      start   = 1'b0;
      acc     = 1'b0;
    end
    dump        = (state_q == DUMP) && enable;
    ack         = bus.out_ack && out_valid_q;
    ovw         = dump && out_valid_q && !bus.out_ack;
    out_valid_d = dump || (out_valid_q && !ack);
    overrun_d   = ovw || (overrun_q && !ack);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_log2_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_log2_q    <= n_log2_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
`ifdef DSP_AVG_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  assign ovf_cnt_d = (ovw && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_cnt_q <= '0;
    else ovf_cnt_q <= ovf_cnt_d;
  assign overrun_cnt = ovf_cnt_q;
`endif
  dsp_avg_lane u_ref (
    .clk(clk), .reset_n(reset_n), .start_i(start), .acc_i(acc), .dump_i(dump), .n_log2_i(n_log2_q),
    .mag_i(bus.mag_ref), .phase_i(bus.phase_ref), .avg_mag_o(bus.avg_mag_ref), .avg_phase_o(bus.avg_phase_ref)
  );
  dsp_avg_lane u_a (
    .clk(clk), .reset_n(reset_n), .start_i(start), .acc_i(acc), .dump_i(dump), .n_log2_i(n_log2_q),
    .mag_i(bus.mag_a), .phase_i(bus.phase_a), .avg_mag_o(bus.avg_mag_a), .avg_phase_o(bus.avg_phase_a)
  );
  dsp_avg_lane u_b (
    .clk(clk), .reset_n(reset_n), .start_i(start), .acc_i(acc), .dump_i(dump), .n_log2_i(n_log2_q),
    .mag_i(bus.mag_b), .phase_i(bus.phase_b), .avg_mag_o(bus.avg_mag_b), .avg_phase_o(bus.avg_phase_b)
  );
  dsp_avg_lane u_c (
    .clk(clk), .reset_n(reset_n), .start_i(start), .acc_i(acc), .dump_i(dump), .n_log2_i(n_log2_q),
    .mag_i(bus.mag_c), .phase_i(bus.phase_c), .avg_mag_o(bus.avg_mag_c), .avg_phase_o(bus.avg_phase_c)
  );
endmodule

// File: tb/tb_dsp_avg.sv
// tb_dsp_avg: self-checking bench for dsp_avg (vector table, handshake/enable/reset sequences, random blocks vs model).
module tb_dsp_avg;
  import dsp_pkg::*;
  typedef logic [W_CORDIC-1:0] mag_t;
  typedef logic [W_PHASE-1:0]  ph_t;
  typedef struct packed {
    logic [3:0]                k;
    logic [3:0]                n;
    logic [3:0][W_CORDIC-1:0]  m;
    logic [3:0][W_PHASE-1:0]   p;
    mag_t                      em;
    ph_t                       ep;
  } vec_t;
  logic       clk = 1'b0, reset_n = 1'b1, enable = 1'b1;
  logic [3:0] avg_log2 = 4'd0;
  int         n_chk = 0, n_fail = 0;
  vec_t       tv [6];
  mag_t       smag [8][4];
  ph_t        sph [8][4];
  dsp_avg_if bus();
`ifdef DSP_AVG_OVF_CNT_EN
  logic [15:0] overrun_cnt;
`endif
  dsp_avg dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .avg_log2(avg_log2),
`ifdef DSP_AVG_OVF_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_all(input string t, input logic v, input mag_t em [4], input ph_t ep [4]);
    check({t, " out_valid"}, 64'(bus.out_valid), 64'(v));
    check({t, " avg_mag_ref"}, 64'(bus.avg_mag_ref), 64'(em[0]));
    check({t, " avg_mag_a"}, 64'(bus.avg_mag_a), 64'(em[1]));
    check({t, " avg_mag_b"}, 64'(bus.avg_mag_b), 64'(em[2]));
    check({t, " avg_mag_c"}, 64'(bus.avg_mag_c), 64'(em[3]));
    check({t, " avg_phase_ref"}, 64'(bus.avg_phase_ref), 64'(ep[0]));
    check({t, " avg_phase_a"}, 64'(bus.avg_phase_a), 64'(ep[1]));
    check({t, " avg_phase_b"}, 64'(bus.avg_phase_b), 64'(ep[2]));
    check({t, " avg_phase_c"}, 64'(bus.avg_phase_c), 64'(ep[3]));
  endtask
  task automatic check_same(input string t, input logic v, input mag_t m, input ph_t p);
    mag_t ma [4];
    ph_t  pa [4];
    for (int l = 0; l < 4; l++) begin ma[l] = m; pa[l] = p; end
    check_all(t, v, ma, pa);
  endtask
  task automatic pulse(input mag_t m [4], input ph_t p [4]);
    bus.mag_ref = m[0]; bus.mag_a = m[1]; bus.mag_b = m[2]; bus.mag_c = m[3];
    bus.phase_ref = p[0]; bus.phase_a = p[1]; bus.phase_b = p[2]; bus.phase_c = p[3];
    bus.in_strobe = 1'b1;
    @(posedge clk);
    #1 bus.in_strobe = 1'b0;
  endtask
  task automatic gap();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input mag_t m [4], input ph_t p [4]);
    pulse(m, p);
    gap();
  endtask
  task automatic pulse1(input mag_t m, input ph_t p);
    mag_t ma [4];
    ph_t  pa [4];
    for (int l = 0; l < 4; l++) begin ma[l] = m; pa[l] = p; end
    pulse(ma, pa);
  endtask
  task automatic send1(input mag_t m, input ph_t p);
    pulse1(m, p);
    gap();
  endtask
  task automatic ack();
    bus.out_ack = 1'b1;
    @(posedge clk);
    #1 bus.out_ack = 1'b0;
  endtask
  // reference: plain block mean of magnitudes, floor mean of wrapped deviations from the first phase
  function automatic mag_t model_mag(input int l, input int k);
    longint s = 0;
    for (int i = 0; i < (1 << k); i++) s += longint'(smag[i][l]);
    return mag_t'(s / (longint'(1) << k));
  endfunction
  function automatic ph_t model_phase(input int l, input int k);
    longint s = 0, d = longint'(1) << k, q;
    for (int i = 0; i < (1 << k); i++) s += longint'(int'(sph[i][l] - sph[0][l]));
    q = s / d;
    if (s % d != 0 && s < 0) q -= 1;
    return sph[0][l] + ph_t'(q);
  endfunction
  initial begin
    mag_t em [4];
    ph_t  ep [4];
    bus.in_strobe = 1'b0; bus.out_ack = 1'b0;
    bus.mag_ref = '0; bus.mag_a = '0; bus.mag_b = '0; bus.mag_c = '0;
    bus.phase_ref = '0; bus.phase_a = '0; bus.phase_b = '0; bus.phase_c = '0;
    tv[0] = {4'd2, 4'd4, {4{31'd1000}}, {4{32'h1000_0000}}, 31'd1000, 32'h1000_0000};
    tv[1] = {4'd1, 4'd2, {31'd0, 31'd0, 31'd4, 31'd3}, {32'h0, 32'h0, 32'h8000_0010, 32'h7FFF_FFF0}, 31'd3, 32'h8000_0000};
    tv[2] = {4'd0, 4'd1, {31'd0, 31'd0, 31'd0, 31'd12345}, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 31'd12345, 32'hDEAD_BEEF};
    tv[3] = {4'd0, 4'd1, {31'd0, 31'd0, 31'd0, 31'h7FFF_FFFF}, {32'h0, 32'h0, 32'h0, 32'h1}, 31'h7FFF_FFFF, 32'h1};
    tv[4] = {4'd2, 4'd4, {31'd4, 31'd3, 31'd2, 31'd1}, {32'h10, 32'h10, 32'h0F, 32'h10}, 31'd2, 32'h0F};
    tv[5] = {4'd2, 4'd4, {4{31'h7FFF_FFFF}}, {32'h8000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000}, 31'h7FFF_FFFF, 32'h8000_0000};
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_same("reset", 1'b0, '0, '0);
    check("reset overrun", 64'(bus.overrun), 64'd0);
    reset_n = 1'b1;
    gap();
    for (int v = 0; v < 6; v++) begin
      avg_log2 = tv[v].k;
      for (int i = 0; i < int'(tv[v].n); i++) begin
        pulse1(tv[v].m[i], tv[v].p[i]);
        if (i == int'(tv[v].n) - 1) check($sformatf("vec%0d valid at T+1", v), 64'(bus.out_valid), 64'd0);
        gap();
      end
      check_same($sformatf("vec%0d", v), 1'b1, tv[v].em, tv[v].ep);
      check($sformatf("vec%0d overrun", v), 64'(bus.overrun), 64'd0);
      ack();
    end
    ack();
    check("stray ack valid", 64'(bus.out_valid), 64'd0);
    check("stray ack overrun", 64'(bus.overrun), 64'd0);
    avg_log2 = 4'd0;
    send1(31'd5, 32'h5);
    send1(31'd6, 32'h6);
    check("overwrite overrun", 64'(bus.overrun), 64'd1);
    check_same("overwrite hold", 1'b1, 31'd6, 32'h6);
`ifdef DSP_AVG_OVF_CNT_EN
    check("overrun_cnt one", 64'(overrun_cnt), 64'd1);
`endif
    pulse1(31'd7, 32'h7);
    bus.out_ack = 1'b1;
    @(posedge clk);
    #1 bus.out_ack = 1'b0;
    check("ack+dump overrun", 64'(bus.overrun), 64'd0);
    check_same("ack+dump", 1'b1, 31'd7, 32'h7);
    ack();
    check("ack clears valid", 64'(bus.out_valid), 64'd0);
    avg_log2 = 4'd2;
    send1(31'd100, 32'h5000_0000);
    send1(31'd100, 32'h5000_0000);
    enable = 1'b0;
    gap();
    gap();
    enable = 1'b1;
    repeat (4) send1(31'd200, 32'h100);
    check_same("enable drop", 1'b1, 31'd200, 32'h100);
    ack();
    avg_log2 = 4'd2;
    send1(31'd10, 32'h20);
    avg_log2 = 4'd0;
    send1(31'd20, 32'h20);
    send1(31'd30, 32'h20);
    check("midblock log2 no early dump", 64'(bus.out_valid), 64'd0);
    send1(31'd40, 32'h20);
    check_same("midblock log2", 1'b1, 31'd25, 32'h20);
    ack();
    send1(31'd77, 32'h77);
    check_same("next block log2", 1'b1, 31'd77, 32'h77);
    ack();
    for (int b = 0; b < 25; b++) begin
      int  k;
      ph_t c;
      k = int'($urandom_range(3, 0));
      c = $urandom;
      avg_log2 = 4'(k);
      for (int i = 0; i < (1 << k); i++) begin
        mag_t ma [4];
        ph_t  pa [4];
        for (int l = 0; l < 4; l++) begin
          smag[i][l] = mag_t'($urandom);
          sph[i][l]  = b[0] ? c + ph_t'($urandom_range(64, 0)) - 32'd32 : ph_t'($urandom);
          ma[l] = smag[i][l];
          pa[l] = sph[i][l];
        end
        send(ma, pa);
      end
      for (int l = 0; l < 4; l++) begin
        em[l] = model_mag(l, k);
        ep[l] = model_phase(l, k);
      end
      check_all($sformatf("rand%0d k=%0d", b, k), 1'b1, em, ep);
      ack();
    end
    avg_log2 = 4'd0;
    send1(31'd9, 32'h9);
    avg_log2 = 4'd2;
    send1(31'd1, 32'h1);
    send1(31'd1, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_same("async reset", 1'b0, '0, '0);
    check("async reset overrun", 64'(bus.overrun), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    avg_log2 = 4'd1;
    send1(31'd8, 32'h100);
    check("post-reset no early dump", 64'(bus.out_valid), 64'd0);
    send1(31'd8, 32'h100);
    check_same("post-reset block", 1'b1, 31'd8, 32'h100);
    ack();
`ifdef DSP_AVG_OVF_CNT_EN
    check("overrun_cnt after reset", 64'(overrun_cnt), 64'd0);
    avg_log2 = 4'd0;
    repeat (4) send1(31'd3, 32'h3);
    check("overrun_cnt three", 64'(overrun_cnt), 64'd3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
